// File: rtl/nibble_acc_seq_pkg.sv
// Shared definitions for the nibble accumulator: FSM state encoding and
// default widths.
package nibble_acc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned ACC_W_DEF = 12;
  localparam int unsigned LEN_W_DEF = 4;

endpackage : nibble_acc_seq_pkg

// File: rtl/nibble_pair_add.sv
// Combinational adder: low nibble plus high nibble of a byte, 5-bit result.
module nibble_pair_add (
  input  logic [7:0] i_data,
  output logic [4:0] o_sum
);

  always_comb begin
    o_sum = {1'b0, i_data[3:0]} + {1'b0, i_data[7:4]};
  end

endmodule : nibble_pair_add

// File: rtl/nibble_acc_seq.sv
// Length-counted job that accumulates the nibble-pair sums of a byte stream,
// with a sticky wrap flag and a one-cycle done pulse.
module nibble_acc_seq
  import nibble_acc_seq_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] result,
  output logic             overflow
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ACC_W-1:0]   r_result;
  logic               r_overflow;
  logic [LEN_W-1:0]   r_remaining;

  logic [4:0]         w_nib_sum;
  logic [ACC_W:0]     w_sum;
  logic               w_accept;
  logic               w_launch;

  nibble_pair_add u_nibble_pair_add (
    .i_data (in_data),
    .o_sum  (w_nib_sum)
  );

  // One extra bit on the sum exposes the wrap for the sticky flag.
  always_comb begin
    w_sum = {1'b0, r_result} + {{(ACC_W - 4){1'b0}}, w_nib_sum};
  end

  always_comb begin
    w_accept = in_valid && (r_state == RUN);
    w_launch = start && (r_state == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = (len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (w_accept && (r_remaining == LEN_W'(1))) begin
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (r_state)
      IDLE: ;
      RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result    <= '0;
      r_overflow  <= 1'b0;
      r_remaining <= '0;
    end else if (w_launch) begin
      r_result    <= '0;
      r_overflow  <= 1'b0;
      r_remaining <= len;
    end else if (w_accept) begin
      r_result    <= w_sum[ACC_W-1:0];
      r_overflow  <= r_overflow | w_sum[ACC_W];
      r_remaining <= r_remaining - LEN_W'(1);
    end
  end

  always_comb begin
    result   = r_result;
    overflow = r_overflow;
  end

endmodule : nibble_acc_seq

// File: tb/tb_nibble_acc_seq.sv
// Directed bench for nibble_acc_seq: a 6-bit and a 12-bit accumulator share
// the same stimulus so the wrap behaviour can be compared side by side.
module tb_nibble_acc_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] len;
  logic       in_valid;
  logic [7:0] in_data;

  logic        rdy6, busy6, done6, ov6;
  logic [5:0]  res6;
  logic        rdy12, busy12, done12, ov12;
  logic [11:0] res12;

  int checks    = 0;
  int failures  = 0;
  int done_cnt  = 0;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done12 === 1'b1) done_cnt++;
  end

  nibble_acc_seq #(.ACC_W(6), .LEN_W(4)) u_dut6 (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (rdy6),
    .busy     (busy6),
    .done     (done6),
    .result   (res6),
    .overflow (ov6)
  );

  nibble_acc_seq #(.ACC_W(12), .LEN_W(4)) u_dut12 (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (rdy12),
    .busy     (busy12),
    .done     (done12),
    .result   (res12),
    .overflow (ov12)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Handshake/status on both instances, then each instance's result and flag.
  task automatic st(input string tag, input logic e_rdy, input logic e_busy,
                    input logic e_done, input int e_r6, input logic e_o6,
                    input int e_r12, input logic e_o12);
    chk({tag, ".rdy6"},  {31'd0, rdy6},   {31'd0, e_rdy});
    chk({tag, ".busy6"}, {31'd0, busy6},  {31'd0, e_busy});
    chk({tag, ".done6"}, {31'd0, done6},  {31'd0, e_done});
    chk({tag, ".res6"},  {26'd0, res6},   e_r6);
    chk({tag, ".ov6"},   {31'd0, ov6},    {31'd0, e_o6});
    chk({tag, ".rdy12"}, {31'd0, rdy12},  {31'd0, e_rdy});
    chk({tag, ".busy12"},{31'd0, busy12}, {31'd0, e_busy});
    chk({tag, ".done12"},{31'd0, done12}, {31'd0, e_done});
    chk({tag, ".res12"}, {20'd0, res12},  e_r12);
    chk({tag, ".ov12"},  {31'd0, ov12},   {31'd0, e_o12});
  endtask

  int dc0;

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0;
    tick(); tick();
    rst = 1'b0;
    st("reset", 0, 0, 0, 0, 0, 0, 0);

    // Basic job: 0x21 -> 3, 0xFF -> +30, 0x00 -> +0 = 33
    dc0 = done_cnt;
    start = 1'b1; len = 4'd3; tick();
    start = 1'b0;
    st("basic.run", 1, 1, 0, 0, 0, 0, 0);
    in_valid = 1'b1; in_data = 8'h21; tick();
    st("basic.b1", 1, 1, 0, 3, 0, 3, 0);
    in_data = 8'hFF; tick();
    st("basic.b2", 1, 1, 0, 33, 0, 33, 0);
    in_data = 8'h00; tick();
    st("basic.done", 0, 1, 1, 33, 0, 33, 0);
    in_valid = 1'b0; tick();
    st("basic.idle", 0, 0, 0, 33, 0, 33, 0);
    chk("basic.done_pulses", done_cnt - dc0, 1);

    // Stall: 0x88 -> 16, four idle cycles, 0x11 -> +2 = 18
    dc0 = done_cnt;
    start = 1'b1; len = 4'd2; tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'h88; tick();
    st("stall.b1", 1, 1, 0, 16, 0, 16, 0);
    in_valid = 1'b0; in_data = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      tick();
      st("stall.hold", 1, 1, 0, 16, 0, 16, 0);
    end
    in_valid = 1'b1; in_data = 8'h11; tick();
    st("stall.done", 0, 1, 1, 18, 0, 18, 0);
    in_valid = 1'b0; tick();
    st("stall.idle", 0, 0, 0, 18, 0, 18, 0);
    chk("stall.done_pulses", done_cnt - dc0, 1);

    // Overflow: 3 x 0xFF = 90; wraps to 26 at 6 bits, fits at 12 bits
    start = 1'b1; len = 4'd3; tick();
    start = 1'b0;
    st("ovf.run", 1, 1, 0, 0, 0, 0, 0);
    in_valid = 1'b1; in_data = 8'hFF; tick();
    st("ovf.b1", 1, 1, 0, 30, 0, 30, 0);
    tick();
    st("ovf.b2", 1, 1, 0, 60, 0, 60, 0);
    tick();
    st("ovf.done", 0, 1, 1, 26, 1, 90, 0);
    in_valid = 1'b0; tick();
    st("ovf.hold1", 0, 0, 0, 26, 1, 90, 0);
    tick();
    st("ovf.hold2", 0, 0, 0, 26, 1, 90, 0);
    start = 1'b1; len = 4'd1; tick();
    start = 1'b0;
    st("ovf.clear", 1, 1, 0, 0, 0, 0, 0);
    in_valid = 1'b1; in_data = 8'h01; tick();
    st("ovf.next", 0, 1, 1, 1, 0, 1, 0);
    in_valid = 1'b0; tick();

    // Zero-length job
    dc0 = done_cnt;
    start = 1'b1; len = 4'd0; tick();
    start = 1'b0;
    st("zero.done", 0, 1, 1, 0, 0, 0, 0);
    tick();
    st("zero.idle", 0, 0, 0, 0, 0, 0, 0);
    chk("zero.done_pulses", done_cnt - dc0, 1);

    // Reset mid-job: 0x12 -> 3, 0x34 -> +7 = 10, then abort
    start = 1'b1; len = 4'd4; tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'h12; tick();
    in_data = 8'h34; tick();
    st("rst.partial", 1, 1, 0, 10, 0, 10, 0);
    dc0 = done_cnt;
    rst = 1'b1; start = 1'b1; in_data = 8'h55; tick();
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    st("rst.abort", 0, 0, 0, 0, 0, 0, 0);
    tick();
    st("rst.idle", 0, 0, 0, 0, 0, 0, 0);
    chk("rst.no_done", done_cnt - dc0, 0);
    start = 1'b1; len = 4'd1; tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'h12; tick();
    st("rst.newjob", 0, 1, 1, 3, 0, 3, 0);
    in_valid = 1'b0; tick();

    // Start in RUN ignored; start in DONE ignored; start in following IDLE honoured
    start = 1'b1; len = 4'd2; tick();
    in_valid = 1'b1; in_data = 8'h01; len = 4'd5; tick();
    st("b2b.run_start_ign", 1, 1, 0, 1, 0, 1, 0);
    start = 1'b0; in_data = 8'h02; tick();
    st("b2b.done1", 0, 1, 1, 3, 0, 3, 0);
    start = 1'b1; len = 4'd1; in_data = 8'h03; tick();
    st("b2b.idle_gap", 0, 0, 0, 3, 0, 3, 0);
    tick();
    st("b2b.launch2", 1, 1, 0, 0, 0, 0, 0);
    start = 1'b0; tick();
    st("b2b.done2", 0, 1, 1, 3, 0, 3, 0);
    in_valid = 1'b0; tick();
    st("b2b.idle", 0, 0, 0, 3, 0, 3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_nibble_acc_seq
